regfile_decoded: RTL and testbench

Parametrised register file built around a one-hot write-address decoder. It generalises the fixed 32-entry write-select decode to 2^ADDR_W entries of WIDTH bits. It adds two registered read ports, an optional hardwired-zero entry 0, and optional write-to-read bypass. It sits in the datapath as the general-purpose register bank behind the instruction decode stage.

---
 rtl/regfile_decoded.sv | 154 +++++++++++++++
 tb/tb_regfile_decoded.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_decoded.sv
// rtl/regfile_decoded.sv - general-purpose register bank: one-hot write decode, two registered read ports.
module regfile_decoded_wr_decode #(
    parameter int ADDR_W = 5
) (
    input  logic                   wr_en,
    input  logic [ADDR_W-1:0]      wr_addr,
    output logic [(1<<ADDR_W)-1:0] wr_sel
);
    localparam int DEPTH = 1 << ADDR_W;

    always_comb begin
        wr_sel = '0;
        for (int i = 0; i < DEPTH; i++) begin
            wr_sel[i] = wr_en && (wr_addr == ADDR_W'(i));
        end
    end
endmodule

module regfile_decoded_rd_port #(
    parameter int WIDTH    = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          rd_en,
    input  logic [ADDR_W-1:0]             rd_addr,
    input  logic                          wr_en,
    input  logic [ADDR_W-1:0]             wr_addr,
    input  logic [WIDTH-1:0]              wr_data,
    input  logic [(1<<ADDR_W)*WIDTH-1:0]  words,
    output logic [WIDTH-1:0]              rd_data,
    output logic                          rd_valid
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [WIDTH-1:0] word_arr [DEPTH];
    logic [WIDTH-1:0] rd_next;

    for (genvar i = 0; i < DEPTH; i++) begin : g_unpack
        assign word_arr[i] = words[i*WIDTH +: WIDTH];
    end

    // Zero-entry rule is applied last so it overrides the bypass path.
    always_comb begin
        rd_next = word_arr[rd_addr];
        if (BYPASS != 0 && wr_en && (wr_addr == rd_addr)) begin
            rd_next = wr_data;
        end
        if (ZERO_REG != 0 && (rd_addr == '0)) begin
            rd_next = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) begin
                rd_data <= rd_next;
            end
        end
    end
endmodule

module regfile_decoded #(
    parameter int WIDTH    = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wr_en,
    input  logic [ADDR_W-1:0]      wr_addr,
    input  logic [WIDTH-1:0]       wr_data,
    output logic [(1<<ADDR_W)-1:0] wr_sel,
    input  logic                   rd_en_a,
    input  logic [ADDR_W-1:0]      rd_addr_a,
    output logic [WIDTH-1:0]       rd_data_a,
    output logic                   rd_valid_a,
    input  logic                   rd_en_b,
    input  logic [ADDR_W-1:0]      rd_addr_b,
    output logic [WIDTH-1:0]       rd_data_b,
    output logic                   rd_valid_b
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [DEPTH*WIDTH-1:0] words;

    regfile_decoded_wr_decode #(
        .ADDR_W (ADDR_W)
    ) u_wr_decode (
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_sel  (wr_sel)
    );

    // wr_sel[0] still decodes when entry 0 is hardwired; the entry just never loads.
    for (genvar i = 0; i < DEPTH; i++) begin : g_entry
        if (ZERO_REG != 0 && i == 0) begin : g_zero
            assign words[i*WIDTH +: WIDTH] = '0;
        end else begin : g_reg
            logic [WIDTH-1:0] q;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    q <= '0;
                end else if (wr_sel[i]) begin
                    q <= wr_data;
                end
            end
            assign words[i*WIDTH +: WIDTH] = q;
        end
    end

    regfile_decoded_rd_port #(
        .WIDTH    (WIDTH),
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG),
        .BYPASS   (BYPASS)
    ) u_rd_a (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_en    (rd_en_a),
        .rd_addr  (rd_addr_a),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .words    (words),
        .rd_data  (rd_data_a),
        .rd_valid (rd_valid_a)
    );

    regfile_decoded_rd_port #(
        .WIDTH    (WIDTH),
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG),
        .BYPASS   (BYPASS)
    ) u_rd_b (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_en    (rd_en_b),
        .rd_addr  (rd_addr_b),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .words    (words),
        .rd_data  (rd_data_b),
        .rd_valid (rd_valid_b)
    );
endmodule

// File: tb/tb_regfile_decoded.sv
// tb/tb_regfile_decoded.sv - default bank and a small no-zero/no-bypass bank against an array model.
module tb_regfile_decoded;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        rd_en_a, rd_en_b;
    logic [4:0]  rd_addr_a, rd_addr_b;

    logic [31:0] sel0, da0, db0;
    logic        va0, vb0;
    logic [7:0]  sel1, da1, db1;
    logic        va1, vb1;

    int n_chk = 0;
    int n_fail = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    regfile_decoded u_dut0 (
        .clk(clk), .rst_n(rst_n),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_sel(sel0),
        .rd_en_a(rd_en_a), .rd_addr_a(rd_addr_a), .rd_data_a(da0), .rd_valid_a(va0),
        .rd_en_b(rd_en_b), .rd_addr_b(rd_addr_b), .rd_data_b(db0), .rd_valid_b(vb0)
    );

    regfile_decoded #(.WIDTH(8), .ADDR_W(3), .ZERO_REG(0), .BYPASS(0)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .wr_en(wr_en), .wr_addr(wr_addr[2:0]), .wr_data(wr_data[7:0]), .wr_sel(sel1),
        .rd_en_a(rd_en_a), .rd_addr_a(rd_addr_a[2:0]), .rd_data_a(da1), .rd_valid_a(va1),
        .rd_en_b(rd_en_b), .rd_addr_b(rd_addr_b[2:0]), .rd_data_b(db1), .rd_valid_b(vb1)
    );

    // Model: index 0 = default bank, index 1 = 8-bit, 8-entry, ordinary entry 0, no bypass.
    int          aw   [2] = '{5, 3};
    int          zr   [2] = '{1, 0};
    int          byp  [2] = '{1, 0};
    logic [31:0] dmask[2] = '{32'hFFFF_FFFF, 32'h0000_00FF};
    logic [31:0] m_mem[2][32];
    logic [31:0] m_da[2], m_db[2];
    logic        m_va[2], m_vb[2];
    int          m_wa, m_ra, m_rb, m_am;
    logic [31:0] m_wd;

    function automatic logic [31:0] rd_val(int k, int a, int wa, logic [31:0] wd, logic we);
        if (zr[k] != 0 && a == 0) return 32'h0;
        if (byp[k] != 0 && we && wa == a) return wd;
        return m_mem[k][a];
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 2; k++) begin
                for (int i = 0; i < 32; i++) m_mem[k][i] = 32'h0;
                m_da[k] = 32'h0; m_db[k] = 32'h0; m_va[k] = 1'b0; m_vb[k] = 1'b0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                m_am = (1 << aw[k]) - 1;
                m_wa = int'(wr_addr) & m_am;
                m_ra = int'(rd_addr_a) & m_am;
                m_rb = int'(rd_addr_b) & m_am;
                m_wd = wr_data & dmask[k];
                m_va[k] = rd_en_a;
                m_vb[k] = rd_en_b;
                if (rd_en_a) m_da[k] = rd_val(k, m_ra, m_wa, m_wd, wr_en);
                if (rd_en_b) m_db[k] = rd_val(k, m_rb, m_wa, m_wd, wr_en);
                if (wr_en && !(zr[k] != 0 && m_wa == 0)) m_mem[k][m_wa] = m_wd;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("va0", {31'h0, va0}, {31'h0, m_va[0]});
            chk("vb0", {31'h0, vb0}, {31'h0, m_vb[0]});
            chk("da0", da0, m_da[0]);
            chk("db0", db0, m_db[0]);
            chk("va1", {31'h0, va1}, {31'h0, m_va[1]});
            chk("vb1", {31'h0, vb1}, {31'h0, m_vb[1]});
            chk("da1", {24'h0, da1}, m_da[1]);
            chk("db1", {24'h0, db1}, m_db[1]);
            chk("sel0", sel0, wr_en ? (32'd1 << wr_addr) : 32'h0);
            chk("sel1", {24'h0, sel1}, wr_en ? (32'd1 << wr_addr[2:0]) : 32'h0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        wr_en = 1'b0; rd_en_a = 1'b0; rd_en_b = 1'b0;
    endtask

    logic [31:0] exp_v;

    initial begin
        idle();
        wr_addr = '0; wr_data = '0; rd_addr_a = '0; rd_addr_b = '0;
        cmp_en = 1'b1;
        repeat (3) tick();
        chk("rst_da0", da0, 32'h0);
        chk("rst_va0", {31'h0, va0}, 32'h0);
        chk("rst_vb1", {31'h0, vb1}, 32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < 32; i++) begin
            rd_en_a = 1'b1; rd_en_b = 1'b1; rd_addr_a = 5'(i); rd_addr_b = 5'(31 - i);
            tick();
            chk("init_valid_a", {31'h0, va0}, 32'h1);
            chk("init_data_b", db0, 32'h0);
        end
        idle();
        tick();
        chk("valid_drop_a", {31'h0, va0}, 32'h0);

        for (int i = 0; i < 32; i++) begin
            wr_en = 1'b1; wr_addr = 5'(i); wr_data = 32'hA5A5_0000 + 32'(i);
            #1 chk("wr_sel_onehot", sel0, 32'd1 << i);
            tick();
        end
        idle();
        for (int i = 0; i < 32; i++) begin
            rd_en_a = 1'b1; rd_en_b = 1'b1; rd_addr_a = 5'(i); rd_addr_b = 5'(i);
            tick();
            exp_v = (i == 0) ? 32'h0 : 32'hA5A5_0000 + 32'(i);
            chk("readback_a", da0, exp_v);
            chk("readback_b", db0, exp_v);
            if (i < 8) chk("readback_small", {24'h0, da1}, 32'(i + 24));
        end

        idle();
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h11;
        tick();
        wr_data = 32'hDEAD_BEEF; rd_en_a = 1'b1; rd_addr_a = 5'd7;
        tick();
        chk("bypass_on", da0, 32'hDEAD_BEEF);
        chk("bypass_off", {24'h0, da1}, 32'h11);
        idle(); rd_en_a = 1'b1;
        tick();
        chk("after_write_small", {24'h0, da1}, 32'hEF);

        idle(); rd_en_b = 1'b1; rd_addr_b = 5'd5;
        tick();
        chk("hold_setup", db0, 32'hA5A5_0005);
        rd_en_b = 1'b0; rd_en_a = 1'b1; rd_addr_a = 5'd3;
        wr_en = 1'b0; wr_addr = 5'd3; wr_data = 32'hFFFF_FFFF;
        #1 chk("sel_disabled", sel0, 32'h0);
        tick();
        chk("hold_valid_b", {31'h0, vb0}, 32'h0);
        chk("hold_data_b", db0, 32'hA5A5_0005);
        chk("no_write_a", da0, 32'hA5A5_0003);
        tick();
        chk("no_write_a2", da0, 32'hA5A5_0003);

        wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h1234_5678;
        rd_en_a = 1'b1; rd_en_b = 1'b1; rd_addr_a = 5'd9; rd_addr_b = 5'd9;
        tick();
        chk("pre_reset_a", da0, 32'h1234_5678);
        #1 rst_n = 1'b0;
        #1;
        chk("async_da0", da0, 32'h0);
        chk("async_va0", {31'h0, va0}, 32'h0);
        chk("async_db1", {24'h0, db1}, 32'h0);
        tick();
        idle();
        rst_n = 1'b1;
        for (int i = 0; i < 32; i++) begin
            rd_en_a = 1'b1; rd_en_b = 1'b1; rd_addr_a = 5'(i); rd_addr_b = 5'(i);
            tick();
            chk("post_reset_a", da0, 32'h0);
        end

        idle(); wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h5A;
        tick();
        idle(); rd_en_a = 1'b1; rd_en_b = 1'b1; rd_addr_a = 5'd0; rd_addr_b = 5'd0;
        tick();
        chk("zero_off_a", {24'h0, da1}, 32'h5A);
        chk("zero_off_b", {24'h0, db1}, 32'h5A);
        chk("zero_on_a", da0, 32'h0);

        for (int c = 0; c < 3000; c++) begin
            wr_en   = ($urandom_range(0, 2) != 0);
            wr_addr = 5'($urandom_range(0, 31));
            wr_data = $urandom;
            rd_en_a = ($urandom_range(0, 3) != 0);
            rd_en_b = ($urandom_range(0, 3) != 0);
            rd_addr_a = ($urandom_range(0, 3) == 0) ? wr_addr : 5'($urandom_range(0, 31));
            rd_addr_b = ($urandom_range(0, 3) == 0) ? rd_addr_a : 5'($urandom_range(0, 31));
            if ($urandom_range(0, 299) == 0) begin
                rst_n = 1'b0;
                tick();
                rst_n = 1'b1;
            end else begin
                tick();
            end
        end

        idle();
        tick();
        cmp_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
